line_buffer_pingpong: RTL

Double-buffered, parametrised line buffer sitting between the pixel generator and the zoom/convolution stages. It fills one line bank while the other is read. Each line can be replayed a programmable number of times for vertical zoom. Alongside the centre pixel it presents a 3-tap horizontal window with selectable border handling for the convolution path. Both sides sustain one pixel per cycle.

---
 rtl/line_buffer_pingpong.sv | 91 +++++++++
 1 files changed

// File: rtl/line_buffer_pingpong.sv
// line_buffer_pingpong: two-bank line buffer with per-line replay and a 3-tap window.
// One bank fills while the other is read; each line replays 1..REPEAT_MAX times.
module line_buffer_pingpong #(
  parameter int PIXEL_WIDTH = 8,
  parameter int LINE_DEPTH  = 640,
  parameter int REPEAT_MAX  = 4,
  parameter int BORDER_MODE = 0,
  localparam int RW = $clog2(REPEAT_MAX + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic [PIXEL_WIDTH-1:0]   wr_pixel,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [RW-1:0]            rd_repeat,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [PIXEL_WIDTH-1:0]   rd_pixel,
  output logic [3*PIXEL_WIDTH-1:0] rd_window,
  output logic                     rd_pass_last,
  output logic                     rd_line_done,
  output logic [1:0]               lines_avail
);
  localparam int IW = $clog2(LINE_DEPTH);
  localparam logic [IW-1:0] LAST = IW'(LINE_DEPTH - 1);
  logic [PIXEL_WIDTH-1:0] r_mem [2][LINE_DEPTH];
  logic                   r_wr_bank, r_rd_bank;
  logic [IW-1:0]          r_wr_idx, r_rd_idx;
  logic [RW-1:0]          r_pass_cnt, r_rep_lat;
  logic [1:0]             r_full;
  logic                   w_wr_hs, w_rd_hs, w_first;
  logic [RW-1:0]          w_req, w_eff;
  logic [PIXEL_WIDTH-1:0] w_border, w_prev, w_next;
  logic [1:0]             w_fill, w_rel;

  assign wr_ready     = !r_full[r_wr_bank];
  assign rd_valid     = r_full[r_rd_bank];
  assign w_wr_hs      = wr_valid && wr_ready;
  assign w_rd_hs      = rd_valid && rd_ready;
  assign w_first      = r_rd_idx == '0 && r_pass_cnt == '0;
  assign w_req        = rd_repeat == '0 ? RW'(1) :
                        rd_repeat > RW'(REPEAT_MAX) ? RW'(REPEAT_MAX) : rd_repeat;
  // The live repeat request only matters on the first beat; later beats use the latched count.
  assign w_eff        = w_first ? w_req : r_rep_lat;
  assign rd_pass_last = rd_valid && r_rd_idx == LAST;
  assign rd_line_done = rd_pass_last && r_pass_cnt == w_eff - RW'(1);
  assign rd_pixel     = r_mem[r_rd_bank][r_rd_idx];
  assign w_border     = BORDER_MODE != 0 ? rd_pixel : '0;
  assign w_prev       = r_rd_idx == '0 ? w_border : r_mem[r_rd_bank][r_rd_idx - IW'(1)];
  assign w_next       = r_rd_idx == LAST ? w_border : r_mem[r_rd_bank][r_rd_idx + IW'(1)];
  assign rd_window    = {w_prev, rd_pixel, w_next};
  assign lines_avail  = {1'b0, r_full[0]} + {1'b0, r_full[1]};
  assign w_fill       = (w_wr_hs && r_wr_idx == LAST) ? 2'b01 << r_wr_bank : 2'b00;
  assign w_rel        = (w_rd_hs && rd_line_done) ? 2'b01 << r_rd_bank : 2'b00;

  always_ff @(posedge clk)
    if (w_wr_hs && !flush) r_mem[r_wr_bank][r_wr_idx] <= wr_pixel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_bank  <= 1'b0;
      r_rd_bank  <= 1'b0;
      r_wr_idx   <= '0;
      r_rd_idx   <= '0;
      r_pass_cnt <= '0;
      r_rep_lat  <= '0;
      r_full     <= '0;
    end else if (flush) begin
      r_wr_bank  <= 1'b0;
      r_rd_bank  <= 1'b0;
      r_wr_idx   <= '0;
      r_rd_idx   <= '0;
      r_pass_cnt <= '0;
      r_full     <= '0;
    end else begin
      if (w_wr_hs) begin
        r_wr_idx <= r_wr_idx == LAST ? '0 : r_wr_idx + IW'(1);
        if (r_wr_idx == LAST) r_wr_bank <= !r_wr_bank;
      end
      if (w_rd_hs) begin
        if (w_first) r_rep_lat <= w_req;
        r_rd_idx   <= rd_pass_last ? '0 : r_rd_idx + IW'(1);
        r_pass_cnt <= rd_line_done ? '0 : rd_pass_last ? r_pass_cnt + RW'(1) : r_pass_cnt;
        if (rd_line_done) r_rd_bank <= !r_rd_bank;
      end
      // Fill and release never target the same bank, so both apply in one cycle.
      r_full <= (r_full | w_fill) & ~w_rel;
    end
  end
endmodule
